// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with fixed access latency and a one-cycle DONE/ERR status.
// Storage is touched only on the BUSY->DONE edge; status encoding equals the FSM state.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_status
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;
    localparam logic [1:0] S_ERR  = 2'b11;

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be >= 1");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("data_mem_responder: BASE_ADDR must be 4-byte aligned");
    end

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          write_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q;
    logic [31:0]   off;
    logic          illegal;
    logic [AW-1:0] idx;
    logic [31:0]   cur;
    logic [31:0]   merged;
    logic          last;

    // Wrapping subtraction makes addresses below BASE_ADDR land out of range.
    always_comb begin
        off     = addr_q - BASE_ADDR;
        illegal = (addr_q[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
        idx     = off[AW+1:2];
        cur     = mem[idx];
        merged  = cur;
        for (int i = 0; i < 4; i++)
            if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
        last    = (state == S_BUSY) && (cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    state   <= S_BUSY;
                    cnt     <= CNT_INIT;
                    write_q <= req_write;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    be_q    <= req_be;
                end
                S_BUSY: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    state   <= illegal ? S_ERR : S_DONE;
                    rdata_q <= illegal ? '0 : (write_q ? merged : cur);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // No reset on storage; a reset during BUSY suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && last && !illegal && write_q) mem[idx] <= merged;
    end

    assign resp_status = state;
    assign resp_rdata  = rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench; expectations come from a behavioural memory model.
module tb_data_mem_responder;
    localparam int unsigned L     = 3;
    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_status;

    logic [31:0] model [DEPTH];
    exp_t        sb [$];
    exp_t        got_e;
    int          n_checks = 0;
    int          n_fail = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_rdata(resp_rdata), .resp_status(resp_status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, output logic [1:0] st);
        exp_t        e;
        logic [31:0] off;
        logic [31:0] m;
        off = a - BASE;
        e.tag = tag;
        if (a[1:0] != 2'b00 || off >= DEPTH * 4) begin
            e.st = 2'b11;
            e.rd = '0;
        end else begin
            m = model[off >> 2];
            if (w) for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
            model[off >> 2] = m;
            e.st = 2'b10;
            e.rd = m;
        end
        st = e.st;
        sb.push_back(e);
    endtask

    task automatic scramble_req();
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    // Full access with per-cycle status sequence check; data is checked by the monitor.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        logic [1:0] st;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
        push_exp(tag, w, a, wd, be, st);
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble_req();
        for (int i = 1; i <= int'(L) + 2; i++) begin
            if (i > 1) begin @(posedge clk); #1; end
            check($sformatf("%s_seq%0d", tag, i), 32'(resp_status),
                  i <= int'(L) ? 32'd1 : (i == int'(L) + 1 ? 32'(st) : 32'd0));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (resp_status == 2'b10 || resp_status == 2'b11)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(resp_status), 32'd0);
            end else begin
                got_e = sb.pop_front();
                check({got_e.tag, "_st"}, 32'(resp_status), 32'(got_e.st));
                check({got_e.tag, "_rd"}, resp_rdata, got_e.rd);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st;
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", 32'(resp_status), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        access("t1_mem0", 1'b0, 32'h1001_0000, 32'h0, 4'h0);
        access("t2_st", 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'b1111);
        access("t2_ld", 1'b0, 32'h1001_0004, 32'h0, 4'h0);
        access("t3_st", 1'b1, 32'h1001_0004, 32'h0000_5500, 4'b0010);
        access("t3_ld", 1'b0, 32'h1001_0004, 32'h0, 4'h0);
        access("t3_be0", 1'b1, 32'h1001_0004, 32'hFFFF_FFFF, 4'b0000);
        access("t4_unal", 1'b1, 32'h1001_0002, 32'h1111_1111, 4'b1111);
        access("t4_high", 1'b1, 32'h1001_1000, 32'h2222_2222, 4'b1111);
        access("t4_low", 1'b0, 32'h1000_FFFC, 32'h0, 4'h0);
        access("t4_last", 1'b0, 32'h1001_0FFC, 32'h0, 4'h0);
        access("t4_lastw", 1'b1, 32'h1001_0FFC, 32'hA5A5_0F0F, 4'b1001);
        access("t4_lastr", 1'b0, 32'h1001_0FFC, 32'h0, 4'h0);
        // Aborted store: nothing pushed to the scoreboard, model left untouched.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1001_0008;
        req_wdata = 32'h1234_5678; req_be = 4'b1111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t5_busy1", 32'(resp_status), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t5_abort_st", 32'(resp_status), 32'd0);
        check("t5_abort_rd", resp_rdata, 32'd0);
        rst = 1'b0;
        access("t5_ld", 1'b0, 32'h1001_0008, 32'h0, 4'h0);
        // Held request: second access starts in the IDLE cycle after DONE.
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1001_0004; req_be = 4'b0000;
        push_exp("t6_a", 1'b0, 32'h1001_0004, 32'h0, 4'h0, st);
        push_exp("t6_b", 1'b0, 32'h1001_0004, 32'h0, 4'h0, st);
        for (int i = 1; i <= 2 * int'(L) + 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin req_write = 1'b1; req_addr = 32'h1001_0002; req_wdata = $urandom; req_be = 4'hF; end
            check($sformatf("t6_seq%0d", i), 32'(resp_status),
                  (i <= int'(L) || (i >= int'(L) + 3 && i <= 2 * int'(L) + 2)) ? 32'd1 :
                  (i == int'(L) + 1 || i == 2 * int'(L) + 3) ? 32'(st) : 32'd0);
            if (i == int'(L) + 1) begin req_write = 1'b0; req_addr = 32'h1001_0004; req_be = 4'h0; end
            if (i == int'(L) + 3) req_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
